pc_seq: RTL and testbench

- Multi-cycle sequencer for the MIPS-C program counter register.
- Fetches each instruction through a request/acknowledge handshake with instruction memory and latches it.
- Waits for the datapath to finish executing, then selects the next PC and drives one PCWrite pulse with the selected address into the PC register's Addr/PCWrite inputs.
- Owns the EPC register and the exception/ERET redirection.

---
 rtl/pc_seq.sv | 115 +++++++++++
 tb/tb_pc_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// Multi-cycle PC sequencer for MIPS-C: fetch handshake, execute wait, next-PC select,
// single-cycle PC write, plus EPC ownership for exception/ERET redirection.
module pc_seq #(
  parameter logic [31:0] EXC_VEC = 32'hBFC00380,
  parameter logic [31:0] RST_VEC = 32'hBFC00000
) (
  input  logic        CLK_I,
  input  logic        Reset_I,
  input  logic [31:0] PC_I,
  output logic [31:0] Addr_O,
  output logic        PCWrite_O,
  output logic        IReq_O,
  input  logic        IAck_I,
  input  logic [31:0] Instr_I,
  output logic [31:0] IR_O,
  input  logic        ExDone_I,
  input  logic        Br_I,
  input  logic        Jmp_I,
  input  logic        Jr_I,
  input  logic [31:0] Rs_I,
  input  logic        Exc_I,
  input  logic        Eret_I,
  output logic [31:0] EPC_O,
  output logic        AdEL_O,
  output logic        Busy_O
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_d, ir_d, epc_d;
  logic        pcw_d, ireq_d, adel_d, busy_d;

  logic [31:0] seq_pc, br_pc, jmp_pc;
  logic        jr_bad;

  assign seq_pc = PC_I + 32'd4;
  assign br_pc  = seq_pc + {{14{IR_O[15]}}, IR_O[15:0], 2'b00};
  assign jmp_pc = {PC_I[31:28], IR_O[25:0], 2'b00};
  assign jr_bad = Jr_I && (Rs_I[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    addr_d  = Addr_O;
    ir_d    = IR_O;
    epc_d   = EPC_O;
    ireq_d  = IReq_O;
    pcw_d   = 1'b0;
    adel_d  = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        ireq_d  = 1'b1;
      end
      FETCH: begin
        if (IAck_I) begin
          ir_d    = Instr_I;
          ireq_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ExDone_I) begin
          state_d = UPDATE;
          pcw_d   = 1'b1;
          // A misaligned JR only faults when no exception/ERET outranks it.
          if (Exc_I || (!Eret_I && jr_bad)) begin
            addr_d = EXC_VEC;
            epc_d  = PC_I;
            adel_d = !Exc_I;
          end else if (Eret_I) begin
            addr_d = EPC_O;
          end else if (Jr_I) begin
            addr_d = Rs_I;
          end else if (Jmp_I) begin
            addr_d = jmp_pc;
          end else if (Br_I) begin
            addr_d = br_pc;
          end else begin
            addr_d = seq_pc;
          end
        end
      end
      UPDATE: begin
        state_d = FETCH;
        ireq_d  = 1'b1;
      end
      default: state_d = BOOT;
    endcase
    busy_d = (state_d != BOOT);
  end

  always_ff @(posedge CLK_I or negedge Reset_I) begin
    if (!Reset_I) begin
      state_q   <= BOOT;
      Addr_O    <= RST_VEC;
      PCWrite_O <= 1'b0;
      IReq_O    <= 1'b0;
      IR_O      <= '0;
      EPC_O     <= '0;
      AdEL_O    <= 1'b0;
      Busy_O    <= 1'b0;
    end else begin
      state_q   <= state_d;
      Addr_O    <= addr_d;
      PCWrite_O <= pcw_d;
      IReq_O    <= ireq_d;
      IR_O      <= ir_d;
      EPC_O     <= epc_d;
      AdEL_O    <= adel_d;
      Busy_O    <= busy_d;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: transaction-level next-PC model plus per-cycle output compare.
module tb_pc_seq;
  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam logic [31:0] RST_VEC = 32'hBFC00000;

  logic        CLK_I = 1'b0, Reset_I = 1'b0;
  logic [31:0] PC_I = '0, Instr_I = '0, Rs_I = '0;
  logic        IAck_I = 1'b0, ExDone_I = 1'b0, Br_I = 1'b0, Jmp_I = 1'b0, Jr_I = 1'b0;
  logic        Exc_I = 1'b0, Eret_I = 1'b0;
  logic [31:0] Addr_O, IR_O, EPC_O;
  logic        PCWrite_O, IReq_O, AdEL_O, Busy_O;

  always #5 CLK_I = ~CLK_I;

  pc_seq #(.EXC_VEC(EXC_VEC), .RST_VEC(RST_VEC)) dut (
    .CLK_I(CLK_I), .Reset_I(Reset_I), .PC_I(PC_I), .Addr_O(Addr_O),
    .PCWrite_O(PCWrite_O), .IReq_O(IReq_O), .IAck_I(IAck_I), .Instr_I(Instr_I),
    .IR_O(IR_O), .ExDone_I(ExDone_I), .Br_I(Br_I), .Jmp_I(Jmp_I), .Jr_I(Jr_I),
    .Rs_I(Rs_I), .Exc_I(Exc_I), .Eret_I(Eret_I), .EPC_O(EPC_O), .AdEL_O(AdEL_O),
    .Busy_O(Busy_O)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr, exp_ir, exp_epc, m_epc;
  logic        exp_pcw, exp_ireq, exp_adel, exp_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK_I) begin
    chk("Addr_O", Addr_O, exp_addr);
    chk("PCWrite_O", 32'(PCWrite_O), 32'(exp_pcw));
    chk("IReq_O", 32'(IReq_O), 32'(exp_ireq));
    chk("IR_O", IR_O, exp_ir);
    chk("EPC_O", EPC_O, exp_epc);
    chk("AdEL_O", 32'(AdEL_O), 32'(exp_adel));
    chk("Busy_O", 32'(Busy_O), 32'(exp_busy));
  end

  // Architectural next-PC rule: priority Exc > Eret > Jr > Jmp > Br > sequential.
  function automatic void model(input logic [31:0] pc, ir, rs,
                                input logic br, jmp, jr, exc, eret,
                                inout logic [31:0] epc,
                                output logic [31:0] addr, output logic adel);
    int off;
    logic misaligned_jr;
    misaligned_jr = jr && (rs % 4 != 0) && !exc && !eret;
    adel = misaligned_jr;
    if (exc || misaligned_jr) begin
      addr = EXC_VEC;
      epc  = pc;
    end else if (eret) addr = epc;
    else if (jr) addr = rs;
    else if (jmp) addr = (pc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
    else if (br) begin
      off  = int'($signed(ir[15:0])) * 4;
      addr = pc + 32'd4 + 32'(off);
    end else addr = pc + 32'd4;
  endfunction

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic set_reset_exp();
    exp_addr = RST_VEC; exp_pcw = 1'b0; exp_ireq = 1'b0; exp_ir = '0;
    exp_epc = '0; exp_adel = 1'b0; exp_busy = 1'b0; m_epc = '0;
  endtask

  // Runs one instruction from FETCH and stops one edge after ExDone (inside UPDATE).
  task automatic to_update(input logic [31:0] pc, instr, input int ackd, exd,
                           input logic br, jmp, jr, input logic [31:0] rs,
                           input logic exc, eret, ack_in_exec);
    logic [31:0] a;
    logic        ad;
    PC_I = pc; Instr_I = instr;
    repeat (ackd) step();
    IAck_I = 1'b1;
    step();
    IAck_I = 1'b0; exp_ir = instr; exp_ireq = 1'b0;
    Instr_I = ~instr; IAck_I = ack_in_exec;
    Br_I = br; Jmp_I = jmp; Jr_I = jr; Rs_I = rs; Exc_I = exc; Eret_I = eret;
    repeat (exd) step();
    ExDone_I = 1'b1;
    step();
    ExDone_I = 1'b0; IAck_I = 1'b0;
    Br_I = 1'b0; Jmp_I = 1'b0; Jr_I = 1'b0; Exc_I = 1'b0; Eret_I = 1'b0;
    model(pc, instr, rs, br, jmp, jr, exc, eret, m_epc, a, ad);
    exp_addr = a; exp_pcw = 1'b1; exp_adel = ad; exp_epc = m_epc;
  endtask

  task automatic leave_update();
    step();
    exp_pcw = 1'b0; exp_adel = 1'b0; exp_ireq = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_reset_exp();
    PC_I = RST_VEC;
    repeat (2) step();
    chk("rst_addr", Addr_O, RST_VEC);
    chk("rst_busy", 32'(Busy_O), 32'd0);
    Reset_I = 1'b1;
    step();
    exp_ireq = 1'b1; exp_busy = 1'b1;
    chk("boot_ireq", 32'(IReq_O), 32'd1);

    // Sequential fetch from the reset vector
    to_update(32'hBFC00000, 32'h24080001, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    chk("t1_ir", IR_O, 32'h24080001);
    chk("t1_addr", Addr_O, 32'hBFC00004);
    chk("t1_pcw", 32'(PCWrite_O), 32'd1);
    leave_update();
    chk("t1_pcw_drop", 32'(PCWrite_O), 32'd0);

    // Branches backward and forward
    to_update(32'hBFC00010, 32'h1000FFFE, 0, 1, 1, 0, 0, '0, 0, 0, 0);
    chk("br_back", Addr_O, 32'hBFC0000C);
    leave_update();
    to_update(32'hBFC00010, 32'h10000004, 0, 0, 1, 0, 0, '0, 0, 0, 0);
    chk("br_fwd", Addr_O, 32'hBFC00024);
    leave_update();

    // Jumps
    to_update(32'hBFC00020, 32'h08000100, 0, 0, 0, 1, 0, '0, 0, 0, 0);
    chk("jmp", Addr_O, 32'hB0000400);
    leave_update();
    to_update(32'hBFC00024, 32'h08000100, 0, 0, 0, 1, 1, 32'h80001000, 0, 0, 0);
    chk("jr_over_jmp", Addr_O, 32'h80001000);
    leave_update();

    // Exception then ERET
    to_update(32'h80000040, 32'h10000004, 0, 0, 1, 0, 0, '0, 1, 0, 0);
    chk("exc_addr", Addr_O, 32'hBFC00380);
    chk("exc_epc", EPC_O, 32'h80000040);
    leave_update();
    to_update(32'hBFC00380, 32'h42000018, 0, 0, 0, 0, 0, '0, 0, 1, 0);
    chk("eret_addr", Addr_O, 32'h80000040);
    leave_update();

    // Misaligned JR
    to_update(32'h80000100, 32'h00400008, 0, 0, 0, 0, 1, 32'h80000002, 0, 0, 0);
    chk("adel_addr", Addr_O, 32'hBFC00380);
    chk("adel_flag", 32'(AdEL_O), 32'd1);
    chk("adel_epc", EPC_O, 32'h80000100);
    leave_update();
    chk("adel_drop", 32'(AdEL_O), 32'd0);

    // Slow ack, stray ack during EXEC, and wrap-around of the sequential PC
    to_update(32'hFFFFFFFC, 32'h00000000, 5, 3, 0, 0, 0, '0, 0, 0, 1);
    chk("wrap", Addr_O, 32'h00000000);
    leave_update();

    // Exception and ERET together: exception wins, EPC overwritten
    to_update(32'h00400000, 32'h00000000, 1, 0, 0, 0, 0, '0, 1, 1, 0);
    chk("exc_eret_addr", Addr_O, 32'hBFC00380);
    chk("exc_eret_epc", EPC_O, 32'h00400000);
    leave_update();

    // Reset asserted during UPDATE
    to_update(32'h00400010, 32'h00000000, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    #1;
    Reset_I = 1'b0;
    set_reset_exp();
    #1;
    chk("rst_upd_pcw", 32'(PCWrite_O), 32'd0);
    chk("rst_upd_addr", Addr_O, RST_VEC);
    chk("rst_upd_busy", 32'(Busy_O), 32'd0);
    repeat (2) step();
    Reset_I = 1'b1;
    step();
    exp_ireq = 1'b1; exp_busy = 1'b1;

    to_update(32'hBFC00000, 32'h24080001, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    chk("post_rst_addr", Addr_O, 32'hBFC00004);
    leave_update();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
